// File: rtl/cipher_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cipher_arbiter_if                                                          |
// | Requester, key-write, response and cipher-core signals of cipher_arbiter.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface cipher_arbiter_if;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        key_wr;
    logic        key_sel;
    logic [2:0]  key_idx;
    logic [7:0]  key_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_id;
    logic        rsp_err;
    logic        cipher_activate;
    logic [7:0]  cipher_in;
    logic [7:0]  cipher_key;
    logic [7:0]  cipher_out;
    logic        cipher_done;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, key_wr, key_sel, key_idx, key_data,
        input  rsp_ready, cipher_out, cipher_done,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
        output cipher_activate, cipher_in, cipher_key
    );

    // Environment side (requesters, consumer, cipher core)
    modport master (
        output req_valid, req_data, key_wr, key_sel, key_idx, key_data,
        output rsp_ready, cipher_out, cipher_done,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
        input  cipher_activate, cipher_in, cipher_key
    );
endinterface
`default_nettype wire

// File: rtl/cipher_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cipher_arbiter                                                             |
// | Round-robin sequencer of the shared XOR cipher for two byte requesters,    |
// | each with its own rolling key. Optional watchdog: CIPHER_TIMEOUT_EN.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cipher_arbiter #(
    parameter int KEY_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    cipher_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    localparam logic [3:0] C_KEY_LEN  = 4'(KEY_LEN);
    localparam logic [2:0] C_PTR_LAST = 3'(KEY_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] key_q [2][8];
    logic [2:0] ptr_q [2];
    logic       prio_q;
    logic       id_q;
    logic [7:0] in_q;
    logic [7:0] ckey_q;
    logic [7:0] rsp_data_q;

    logic       gnt;
    logic       handshake;
    logic       done_take;
    logic       rsp_fire;
    logic       timeout;
    logic       adv_ok;
    logic       key_wr_ok;
    logic       activate;
    logic       rsp_valid;

    // A lone valid requester wins; on contention prio_q names the one not served last.
    always_comb begin
        gnt = prio_q;
        if (bus.req_valid == 2'b01) begin
            gnt = 1'b0;
        end else if (bus.req_valid == 2'b10) begin
            gnt = 1'b1;
        end
    end

    assign handshake = (state_q == S_IDLE) && bus.req_valid[gnt];
    assign done_take = (state_q == S_WAIT) && bus.cipher_done;
    assign rsp_fire  = (state_q == S_RESPOND) && bus.rsp_ready;
    assign key_wr_ok = bus.key_wr && ({1'b0, bus.key_idx} < C_KEY_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        activate  = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                activate = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (done_take || timeout) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CIPHER_TIMEOUT_EN
    localparam int             TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmr_q;
    logic          rsp_err_q;

    // A done arriving on the last allowed cycle still counts as a good result.
    assign timeout = (state_q == S_WAIT) && (tmr_q == C_TMO_LAST) && !bus.cipher_done;
    assign adv_ok  = !rsp_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if ((state_q == S_WAIT) && !timeout && !bus.cipher_done) begin
                tmr_q <= tmr_q + 1'b1;
            end else begin
                tmr_q <= '0;
            end
            if (done_take) begin
                rsp_err_q <= 1'b0;
            end else if (timeout) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign timeout     = 1'b0;
    assign adv_ok      = 1'b1;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                ptr_q[r] <= '0;
                for (int b = 0; b < 8; b++) begin
                    key_q[r][b] <= '0;
                end
            end
            prio_q     <= 1'b0;
            id_q       <= 1'b0;
            in_q       <= '0;
            ckey_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            if (handshake) begin
                id_q   <= gnt;
                in_q   <= gnt ? bus.req_data[15:8] : bus.req_data[7:0];
                ckey_q <= key_q[gnt][ptr_q[gnt]];
            end
            if (done_take) begin
                rsp_data_q <= bus.cipher_out;
            end else if (timeout) begin
                rsp_data_q <= '0;
            end
            if (rsp_fire) begin
                prio_q <= ~id_q;
                if (adv_ok) begin
                    ptr_q[id_q] <= (ptr_q[id_q] == C_PTR_LAST) ? 3'd0 : ptr_q[id_q] + 3'd1;
                end
            end
            // A key write to index 0 restarts that requester's key sequence, winning over an advance.
            if (key_wr_ok) begin
                key_q[bus.key_sel][bus.key_idx] <= bus.key_data;
                if (bus.key_idx == 3'd0) begin
                    ptr_q[bus.key_sel] <= '0;
                end
            end
        end
    end

    assign bus.req_ready       = handshake ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign bus.cipher_activate = activate;
    assign bus.cipher_in       = in_q;
    assign bus.cipher_key      = ckey_q;
    assign bus.rsp_valid       = rsp_valid;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.rsp_id          = id_q;
endmodule
`default_nettype wire

// File: tb/tb_cipher_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cipher_arbiter                                                          |
// | Self-checking bench: vector tables, scoreboard queue, XOR cipher model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cipher_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cipher_arbiter_if bus_if();

    cipher_arbiter #(
        .KEY_LEN        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic       id;
        logic       err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        bit         kw;
        logic [2:0] kidx;
        logic [7:0] kdat;
        logic       id;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         n_cmp  = 0;
    int         n_fail = 0;
    bit         suppress_done = 1'b0;
    logic [7:0] ci, ck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_write(input logic sel, input logic [2:0] idx, input logic [7:0] dat);
        bus_if.key_wr   = 1'b1;
        bus_if.key_sel  = sel;
        bus_if.key_idx  = idx;
        bus_if.key_data = dat;
        tick();
        bus_if.key_wr   = 1'b0;
    endtask

    task automatic send(input logic id, input logic [7:0] data, input logic [7:0] exp,
                        input logic err, input bit push);
        bit ok = 1'b0;
        if (id) bus_if.req_data[15:8] = data;
        else    bus_if.req_data[7:0]  = data;
        bus_if.req_valid[id] = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.req_ready[id]) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: requester %0d got no req_ready want 1", id);
        end else if (push) begin
            sbq.push_back('{id: id, err: err, data: exp});
        end
        tick();
        bus_if.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !bus_if.rsp_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses want 0", sbq.size());
        end
        tick();
    endtask

    function automatic logic [31:0] out_vec();
        return {2'b00, bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_id,
                bus_if.rsp_err, bus_if.cipher_activate, bus_if.cipher_in, bus_if.cipher_key};
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        bus_if.req_valid = 2'b00;
        bus_if.key_wr    = 1'b0;
        bus_if.rsp_ready = 1'b1;
        repeat (2) tick();
        check("reset_outputs", out_vec(), 32'd0);
        rst = 1'b0;
        tick();
    endtask

    // Scoreboard consumer: every accepted response pops one expectation.
    always @(negedge clk) begin
        if (!rst && bus_if.rsp_valid && bus_if.rsp_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d data %0h want none", bus_if.rsp_id, bus_if.rsp_data);
            end else begin
                mon_e = sbq.pop_front();
                check("rsp_id_err_data", {22'd0, bus_if.rsp_id, bus_if.rsp_err, bus_if.rsp_data},
                      {22'd0, mon_e});
            end
        end
    end

    // Cipher core: samples one cycle after activate, done pulse 3 cycles after activate.
    initial begin
        bus_if.cipher_done = 1'b0;
        bus_if.cipher_out  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_if.cipher_activate) begin
                @(negedge clk);
                ci = bus_if.cipher_in;
                ck = bus_if.cipher_key;
                @(negedge clk);
                @(posedge clk);
                #1;
                if (!suppress_done) begin
                    bus_if.cipher_out  = ci ^ ck;
                    bus_if.cipher_done = 1'b1;
                    @(posedge clk);
                    #1;
                    bus_if.cipher_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t tab1[6];
        vec_t tab6[5];
        logic ord[4];
        logic exp_ord[4];
        int   ng;
        bit   seen;

        tab1[0] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hF0, 8'hE1};
        tab1[1] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hF0, 8'hD2};
        tab1[2] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hF0, 8'hC3};
        tab1[3] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hF0, 8'hB4};
        tab1[4] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hF0, 8'hE1};
        tab1[5] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h3C, 8'h3C};

        tab6[0] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h04};
        tab6[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h01};
        tab6[2] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h02};
        tab6[3] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'hA5};
        tab6[4] = '{1'b1, 3'd0, 8'h33, 1'b1, 8'h00, 8'h33};

        exp_ord[0] = 1'b0; exp_ord[1] = 1'b1; exp_ord[2] = 1'b0; exp_ord[3] = 1'b1;

        bus_if.req_valid = 2'b00;
        bus_if.req_data  = 16'h0000;
        bus_if.key_wr    = 1'b0;
        bus_if.key_sel   = 1'b0;
        bus_if.key_idx   = 3'd0;
        bus_if.key_data  = 8'h00;
        bus_if.rsp_ready = 1'b1;
        #1;

        // Rolling key for A with wrap, then one B byte against a zero key
        reset_dut();
        key_write(1'b0, 3'd0, 8'h11);
        key_write(1'b0, 3'd1, 8'h22);
        key_write(1'b0, 3'd2, 8'h33);
        key_write(1'b0, 3'd3, 8'h44);
        for (int i = 0; i < 6; i++) begin
            if (tab1[i].kw) key_write(tab1[i].id, tab1[i].kidx, tab1[i].kdat);
            send(tab1[i].id, tab1[i].data, tab1[i].exp, 1'b0, 1'b1);
            drain();
        end

        // Continuous contention: grants alternate starting with A
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            key_write(1'b0, 3'(i), 8'h0F);
            key_write(1'b1, 3'(i), 8'hF0);
        end
        bus_if.req_data  = 16'h0000;
        bus_if.req_valid = 2'b11;
        ng = 0;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            @(negedge clk);
            if (bus_if.req_ready[0]) begin
                sbq.push_back('{id: 1'b0, err: 1'b0, data: 8'h0F});
                ord[ng] = 1'b0;
                ng++;
            end else if (bus_if.req_ready[1]) begin
                sbq.push_back('{id: 1'b1, err: 1'b0, data: 8'hF0});
                ord[ng] = 1'b1;
                ng++;
            end
        end
        tick();
        bus_if.req_valid = 2'b00;
        check("grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) check($sformatf("grant_order_%0d", i), {31'd0, ord[i]}, {31'd0, exp_ord[i]});
        drain();

        // Consumer stall: response held, no new grant, no activate
        bus_if.rsp_ready = 1'b0;
        send(1'b0, 8'h00, 8'h0F, 1'b0, 1'b1);
        bus_if.req_valid = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid) seen = 1'b1;
        end
        check("stall_rsp_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall_hold", {19'd0, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_id,
                                 bus_if.req_ready, bus_if.cipher_activate},
                  {19'd0, 1'b1, 8'h0F, 1'b0, 2'b00, 1'b0});
            @(negedge clk);
        end
        tick();
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 1'b1;
        drain();

        // Reset during WAIT: immediate clear, pointer restarts at 0
        reset_dut();
        send(1'b1, 8'h11, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("rst_in_wait", out_vec(), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        key_write(1'b1, 3'd0, 8'h5A);
        send(1'b1, 8'h5A, 8'h00, 1'b0, 1'b1);
        drain();

        // Key write to the in-flight requester leaves the latched key alone
        reset_dut();
        key_write(1'b1, 3'd0, 8'h01);
        key_write(1'b1, 3'd1, 8'h02);
        key_write(1'b1, 3'd2, 8'h03);
        key_write(1'b1, 3'd3, 8'h04);
        send(1'b1, 8'h00, 8'h01, 1'b0, 1'b1);
        drain();
        send(1'b1, 8'h00, 8'h02, 1'b0, 1'b1);
        drain();
        send(1'b1, 8'h00, 8'h03, 1'b0, 1'b1);
        key_write(1'b1, 3'd2, 8'hA5);
        drain();
        for (int i = 0; i < 5; i++) begin
            if (tab6[i].kw) key_write(tab6[i].id, tab6[i].kidx, tab6[i].kdat);
            send(tab6[i].id, tab6[i].data, tab6[i].exp, 1'b0, 1'b1);
            drain();
        end

`ifdef CIPHER_TIMEOUT_EN
        // Watchdog: no done -> erred zero result after 16 WAIT cycles, pointer held
        begin
            int cnt;
            reset_dut();
            key_write(1'b0, 3'd0, 8'h11);
            key_write(1'b0, 3'd1, 8'h22);
            suppress_done = 1'b1;
            send(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
            tick();
            cnt  = 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (bus_if.rsp_valid) seen = 1'b1;
                else cnt++;
            end
            check("tmo_latency", 32'(cnt), 32'd16);
            drain();
            suppress_done = 1'b0;
            repeat (4) tick();
            send(1'b0, 8'h00, 8'h11, 1'b0, 1'b1);
            drain();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
